// File: rtl/sram_req_adapter.sv
// Valid/ready front end for the single-port SRAM macro: drives the macro port
// combinationally and returns read data through a credit-protected response FIFO.
module sram_req_adapter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024,
    parameter int LATENCY    = 1,
    parameter int RSP_DEPTH  = 2,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  wr_err_o,
    output logic                  busy_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + LATENCY + 1);
    localparam logic [AW:0] LP_NUM_WORDS = (AW + 1)'(NUM_WORDS);

    logic            w_in_range;
    logic            w_acc;
    logic            w_rd_acc;
    logic            w_pop;
    logic            w_push;
    logic            w_credit_ok;
    logic            w_exit_vld;
    logic            w_exit_err;
    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_credit_sum;

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
    logic                  r_fifo_err  [RSP_DEPTH];
    logic                  r_wr_err;

    function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_in_range   = {1'b0, req_addr_i} < LP_NUM_WORDS;
        w_pop        = rsp_valid_o & rsp_ready_i;
        // Pop credit lets a full FIFO keep accepting reads while it drains.
        w_credit_sum = r_cnt + w_inflight - CW'(w_pop);
        w_credit_ok  = w_credit_sum < CW'(RSP_DEPTH);
        req_ready_o  = !rst_i && (req_we_i || w_credit_ok);
        w_acc        = req_valid_i & req_ready_o;
        w_rd_acc     = w_acc & ~req_we_i;
        sram_req_o   = w_acc & w_in_range;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
        w_push       = w_exit_vld;
    end

    // Stage 0 is the accept cycle; stages 1..LATENCY-1 track reads awaiting macro data.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_exit_vld = w_rd_acc;
            assign w_exit_err = ~w_in_range;
            assign w_inflight = '0;
        end else begin : g_latn
            logic [LATENCY-1:1] r_vld_p;
            logic [LATENCY-1:1] r_err_p;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_vld_p <= '0;
                end else begin
                    r_vld_p[1] <= w_rd_acc;
                    for (int k = 2; k < LATENCY; k++) r_vld_p[k] <= r_vld_p[k-1];
                end
            end

            always_ff @(posedge clk_i) begin
                r_err_p[1] <= ~w_in_range;
                for (int k = 2; k < LATENCY; k++) r_err_p[k] <= r_err_p[k-1];
            end

            always_comb begin
                w_inflight = '0;
                for (int k = 1; k < LATENCY; k++) w_inflight = w_inflight + CW'(r_vld_p[k]);
            end

            assign w_exit_vld = r_vld_p[LATENCY-1];
            assign w_exit_err = r_err_p[LATENCY-1];
        end
    endgenerate

    // Response FIFO control
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= f_ptr_next(r_wptr);
            if (w_pop)  r_rptr <= f_ptr_next(r_rptr);
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_wr_err <= w_acc & req_we_i & ~w_in_range;
        end
    end

    // Out-of-range reads never touched the macro, so their payload is forced to zero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= w_exit_err ? '0 : sram_rdata_i;
            r_fifo_err[r_wptr]  <= w_exit_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_push && !w_pop && r_cnt == CW'(RSP_DEPTH)))
                else $error("response FIFO push while full");
        end
    end

    assign rsp_valid_o = (r_cnt != '0);
    assign rsp_rdata_o = rsp_valid_o ? r_fifo_data[r_rptr] : '0;
    assign rsp_err_o   = rsp_valid_o & r_fifo_err[r_rptr];
    assign wr_err_o    = r_wr_err;
    assign busy_o      = (w_inflight != '0) | rsp_valid_o;

endmodule
